fpu_cw_sw_unit: RTL and testbench
=================================

Name: fpu_cw_sw_unit

Overview:
Next-generation 8087 control/status front-end for the FPU core. It holds the control word and decodes its fields. It also provides a parametrised save/restore stack of control words, so microcode can temporarily override rounding or precision (for example, FIST truncation) and restore the original. It accumulates sticky exception flags and generates the error-summary bit and a registered interrupt request.

Parameters:
CW_RESET, 16'h037F, control word value loaded by reset and by finit.
SAVE_DEPTH, 4, number of entries in the control-word save stack (power of two, minimum 2).
NUM_EXC, 6, number of exception flags, ordered IE, DE, ZE, OE, UE, PE (bit 0 = IE). Fixed at 6 for 8087 encoding.

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high
cw_in  in  16  new control word (FLDCW)
cw_we  in  1  load cw_in
cw_push  in  1  push current control word onto the save stack
cw_pop  in  1  restore control word from the top of the save stack
finit  in  1  reinitialise the control word, the save stack and the flags
fclex  in  1  clear the sticky exception flags
exc_valid  in  1  exc_in qualifies this cycle
exc_in  in  NUM_EXC  exception events from the datapath
cw_out  out  16  current control word
rounding_mode  out  2  cw[11:10]
precision_mode  out  2  cw[9:8]
iem  out  1  cw[7], interrupt enable mask
exc_mask  out  NUM_EXC  cw[5:0]
exc_flags  out  NUM_EXC  sticky exception flags
es  out  1  error summary = |(exc_flags & ~exc_mask)
int_req  out  1  registered interrupt request
stk_full  out  1  save stack holds SAVE_DEPTH entries
stk_empty  out  1  save stack holds no entries
stk_err  out  1  one-cycle pulse on stack overflow, stack underflow, or push and pop in the same cycle

Behaviour:
Reset values:
- cw = CW_RESET; exc_flags = 0; stack count = 0; stk_empty = 1; stk_full = 0; stk_err = 0; int_req = 0.
- The stack storage contents are don't-care after reset.

Control-word update, per clock edge, in priority order:
1. finit: cw <= CW_RESET; stack count <= 0; exc_flags <= 0. All other inputs in that cycle are ignored.
2. cw_push and cw_pop both high: stk_err pulses; cw and the stack are unchanged; a cw_we in the same cycle still applies.
3. cw_pop:
   - If the stack is non-empty: cw <= top entry; count decrements.
   - If the stack is empty: stk_err pulses; cw is unchanged.
   - cw_we in the same cycle is ignored (the pop wins).
4. cw_push:
   - If not full: the current (pre-write) cw is stored at the top; count increments.
   - If full: stk_err pulses; nothing is stored.
   - A cw_we in the same cycle loads cw_in. This is the atomic "save and override" operation.
5. cw_we alone: cw <= cw_in.

Control-word rules:
- Reserved bits [15:13] and [6] are stored as written. cw_out reflects them.
- Decoded outputs are combinational from the cw register. A write is visible on the cycle after the edge.

Exception flags:
- When exc_valid is high: exc_flags <= exc_flags | exc_in.
- When fclex is high: flags are cleared.
- fclex and exc_valid in the same cycle: exc_flags <= exc_in (a new event survives the clear).
- finit overrides both.

Error summary and interrupt:
- es is combinational from exc_flags and the current exc_mask. Unmasking an already-set flag through cw_we raises es on the next cycle.
- int_req <= es & ~iem, so it lags es by one cycle. It deasserts one cycle after fclex, finit, masking of the flag, or setting iem.

Stack status:
- stk_full and stk_empty are combinational from the count.
- stk_err is registered and high for exactly one cycle per faulting request.

Timing:
- No multi-cycle operations. Every request completes in one clock.
- Asserting reset mid-sequence returns all outputs to their reset values immediately.

Decomposition:
Shared package fpu_cw_pkg contains:
- CW_RESET_DEFAULT
- field bit positions: RC_HI/RC_LO, PC_HI/PC_LO, IEM_BIT, mask bits 0–5
- exception index constants EXC_IE, EXC_DE, EXC_ZE, EXC_OE, EXC_UE, EXC_PE
- rounding-mode encodings RC_NEAREST, RC_DOWN, RC_UP, RC_TRUNC
- precision-mode encodings PC_24, PC_53, PC_64

Sub-module: fpu_cw_save_stack, a parametrised LIFO of SAVE_DEPTH x 16 with count, full/empty and error flagging. The top level holds the cw and flag registers and the priority logic.

Test Plan:
1. Reset, then no stimulus -> cw_out = 037F, rounding_mode = 00, precision_mode = 11, exc_mask = 3F, stk_empty = 1, int_req = 0.
2. cw_push together with cw_we (cw_in = 0F7F), then cw_pop -> cw_out = 0F7F with rounding_mode = 11 after the first edge; cw_out = 037F after the pop; stk_empty = 1 again.
3. Push 5 times with SAVE_DEPTH = 4 (writing distinct cw values between pushes) -> stk_full after the 4th push; stk_err pulses once on the 5th; four pops return the saved values in reverse order; a 5th pop pulses stk_err and leaves cw unchanged.
4. cw_we = 0360 (ZE unmasked, iem = 0), then exc_valid with exc_in = 04 -> exc_flags = 04; es = 1 on the next cycle; int_req = 1 one cycle later. Then fclex -> flags = 0, es = 0, int_req = 0 one cycle after.
5. fclex and exc_valid (exc_in = 20) in the same cycle with flags = 05 -> exc_flags = 20. Set iem (cw = 03E0) with ZE still unmasked -> int_req drops.
6. Push 2 entries, set flags = 3F, then finit together with cw_we and cw_push -> cw = 037F, flags = 0, stk_empty = 1, stk_err = 0. Then assert async reset mid-push -> all outputs return to reset values without waiting for a clock.

Source files
------------

// File: rtl/fpu_cw_pkg.sv
// Shared constants for the FPU control-word front-end: field positions,
// exception indices and rounding/precision encodings.
package fpu_cw_pkg;

    localparam logic [15:0] CW_RESET_DEFAULT = 16'h037F;

    localparam int unsigned CW_W    = 16;
    localparam int unsigned RC_HI   = 11;
    localparam int unsigned RC_LO   = 10;
    localparam int unsigned PC_HI   = 9;
    localparam int unsigned PC_LO   = 8;
    localparam int unsigned IEM_BIT = 7;

    localparam int unsigned MASK_IM = 0;
    localparam int unsigned MASK_DM = 1;
    localparam int unsigned MASK_ZM = 2;
    localparam int unsigned MASK_OM = 3;
    localparam int unsigned MASK_UM = 4;
    localparam int unsigned MASK_PM = 5;

    localparam int unsigned EXC_IE = 0;
    localparam int unsigned EXC_DE = 1;
    localparam int unsigned EXC_ZE = 2;
    localparam int unsigned EXC_OE = 3;
    localparam int unsigned EXC_UE = 4;
    localparam int unsigned EXC_PE = 5;

    localparam logic [1:0] RC_NEAREST = 2'b00;
    localparam logic [1:0] RC_DOWN    = 2'b01;
    localparam logic [1:0] RC_UP      = 2'b10;
    localparam logic [1:0] RC_TRUNC   = 2'b11;

    localparam logic [1:0] PC_24 = 2'b00;
    localparam logic [1:0] PC_53 = 2'b10;
    localparam logic [1:0] PC_64 = 2'b11;

endpackage

// File: rtl/fpu_cw_save_stack.sv
// LIFO of saved control words with occupancy flags and a one-cycle error pulse
// on overflow, underflow or a simultaneous push/pop.
module fpu_cw_save_stack
    import fpu_cw_pkg::*;
#(
    parameter int unsigned SAVE_DEPTH = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            clr,
    input  logic            push,
    input  logic            pop,
    input  logic [CW_W-1:0] din,
    output logic [CW_W-1:0] dout,
    output logic            full,
    output logic            empty,
    output logic            err
);

    localparam int unsigned AW  = $clog2(SAVE_DEPTH);
    localparam int unsigned CNW = AW + 1;

    logic [CW_W-1:0] mem_q [SAVE_DEPTH];
    logic [CW_W-1:0] mem_d [SAVE_DEPTH];
    logic [CNW-1:0]  count_q, count_d;
    logic            err_q, err_d;

    assign full  = (count_q == CNW'(SAVE_DEPTH));
    assign empty = (count_q == '0);
    assign err   = err_q;
    // Top entry; index wraps when empty but is never consumed then.
    assign dout  = mem_q[AW'(count_q - CNW'(1))];

    always_comb begin
        count_d = count_q;
        err_d   = 1'b0;
        mem_d   = mem_q;
        if (clr) begin
            count_d = '0;
        end else if (push && pop) begin
            err_d = 1'b1;
        end else if (pop) begin
            if (empty) err_d = 1'b1;
            else       count_d = count_q - CNW'(1);
        end else if (push) begin
            if (full) begin
                err_d = 1'b1;
            end else begin
                mem_d[AW'(count_q)] = din;
                count_d             = count_q + CNW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
            err_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            err_q   <= err_d;
        end
    end

    // Storage is not reset; contents are meaningless while count is zero.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/fpu_cw_sw_unit.sv
// 8087-style control word, save stack, sticky exception flags, error summary
// and registered interrupt request.
module fpu_cw_sw_unit
    import fpu_cw_pkg::*;
#(
    parameter logic [15:0] CW_RESET   = CW_RESET_DEFAULT,
    parameter int unsigned SAVE_DEPTH = 4,
    parameter int unsigned NUM_EXC    = 6
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [15:0]        cw_in,
    input  logic               cw_we,
    input  logic               cw_push,
    input  logic               cw_pop,
    input  logic               finit,
    input  logic               fclex,
    input  logic               exc_valid,
    input  logic [NUM_EXC-1:0] exc_in,
    output logic [15:0]        cw_out,
    output logic [1:0]         rounding_mode,
    output logic [1:0]         precision_mode,
    output logic               iem,
    output logic [NUM_EXC-1:0] exc_mask,
    output logic [NUM_EXC-1:0] exc_flags,
    output logic               es,
    output logic               int_req,
    output logic               stk_full,
    output logic               stk_empty,
    output logic               stk_err
);

    logic [CW_W-1:0]    cw_q, cw_d;
    logic [NUM_EXC-1:0] exc_flags_q, exc_flags_d;
    logic               int_req_q, int_req_d;
    logic [CW_W-1:0]    stk_top;

    fpu_cw_save_stack #(
        .SAVE_DEPTH (SAVE_DEPTH)
    ) u_stack (
        .clk   (clk),
        .reset (reset),
        .clr   (finit),
        .push  (cw_push),
        .pop   (cw_pop),
        .din   (cw_q),
        .dout  (stk_top),
        .full  (stk_full),
        .empty (stk_empty),
        .err   (stk_err)
    );

    assign cw_out         = cw_q;
    assign rounding_mode  = cw_q[RC_HI:RC_LO];
    assign precision_mode = cw_q[PC_HI:PC_LO];
    assign iem            = cw_q[IEM_BIT];
    assign exc_mask       = cw_q[NUM_EXC-1:0];
    assign exc_flags      = exc_flags_q;
    assign es             = |(exc_flags_q & ~exc_mask);
    assign int_req        = int_req_q;

    // A lone pop owns the cw (even when it underflows); otherwise cw_we applies.
    always_comb begin
        cw_d        = cw_q;
        exc_flags_d = exc_flags_q;
        int_req_d   = es & ~iem;
        if (finit) begin
            cw_d        = CW_RESET;
            exc_flags_d = '0;
        end else begin
            if (cw_pop && !cw_push) begin
                if (!stk_empty) cw_d = stk_top;
            end else if (cw_we) begin
                cw_d = cw_in;
            end
            if (fclex) begin
                exc_flags_d = exc_valid ? exc_in : '0;
            end else if (exc_valid) begin
                exc_flags_d = exc_flags_q | exc_in;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cw_q        <= CW_RESET;
            exc_flags_q <= '0;
            int_req_q   <= 1'b0;
        end else begin
            cw_q        <= cw_d;
            exc_flags_q <= exc_flags_d;
            int_req_q   <= int_req_d;
        end
    end

endmodule

// File: tb/tb_fpu_cw_sw_unit.sv
// Directed scenarios plus randomized traffic checked against a queue-based
// model of the control-word unit.
module tb_fpu_cw_sw_unit;

    localparam logic [15:0] CWR   = 16'h037F;
    localparam int          DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] cw_in;
    logic        cw_we, cw_push, cw_pop, finit, fclex, exc_valid;
    logic [5:0]  exc_in;
    logic [15:0] cw_out;
    logic [1:0]  rounding_mode, precision_mode;
    logic        iem;
    logic [5:0]  exc_mask, exc_flags;
    logic        es, int_req, stk_full, stk_empty, stk_err;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    logic [15:0] m_cw;
    logic [5:0]  m_flags;
    logic        m_int, m_err;
    logic [15:0] m_stk [$];

    fpu_cw_sw_unit #(.CW_RESET(CWR), .SAVE_DEPTH(DEPTH), .NUM_EXC(6)) dut (
        .clk(clk), .reset(reset), .cw_in(cw_in), .cw_we(cw_we),
        .cw_push(cw_push), .cw_pop(cw_pop), .finit(finit), .fclex(fclex),
        .exc_valid(exc_valid), .exc_in(exc_in), .cw_out(cw_out),
        .rounding_mode(rounding_mode), .precision_mode(precision_mode),
        .iem(iem), .exc_mask(exc_mask), .exc_flags(exc_flags), .es(es),
        .int_req(int_req), .stk_full(stk_full), .stk_empty(stk_empty),
        .stk_err(stk_err)
    );

    always #5 clk = ~clk;

    task automatic idle();
        cw_in = 16'h0; cw_we = 0; cw_push = 0; cw_pop = 0;
        finit = 0; fclex = 0; exc_valid = 0; exc_in = 6'h0;
    endtask

    function automatic logic m_es();
        return |(m_flags & ~m_cw[5:0]);
    endfunction

    task automatic model_reset();
        m_cw = CWR; m_flags = 6'h0; m_int = 0; m_err = 0;
        m_stk.delete();
    endtask

    // Advance the model by one clock using the currently driven inputs.
    task automatic model_step();
        logic [15:0] ncw;
        logic [5:0]  nfl;
        logic        nerr;
        logic        nint;
        nint = m_es() & ~m_cw[7];
        ncw  = m_cw; nfl = m_flags; nerr = 0;
        if (finit) begin
            ncw = CWR; nfl = 6'h0; m_stk.delete();
        end else begin
            if (cw_push && cw_pop) begin
                nerr = 1;
                if (cw_we) ncw = cw_in;
            end else if (cw_pop) begin
                if (m_stk.size() == 0) nerr = 1;
                else ncw = m_stk.pop_back();
            end else if (cw_push) begin
                if (m_stk.size() == DEPTH) nerr = 1;
                else m_stk.push_back(m_cw);
                if (cw_we) ncw = cw_in;
            end else if (cw_we) begin
                ncw = cw_in;
            end
            if (fclex) nfl = exc_valid ? exc_in : 6'h0;
            else if (exc_valid) nfl = m_flags | exc_in;
        end
        m_cw = ncw; m_flags = nfl; m_err = nerr; m_int = nint;
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        idle();
        reset = 1;
        model_reset();
        @(posedge clk);
        #1;
        reset = 0;
    endtask

    task automatic test_reset();
        apply_reset();
        tick();
        checks++; if (cw_out !== 16'h037F) begin failures++; $display("FAIL reset_cw got=%h exp=037F", cw_out); end
        checks++; if (rounding_mode !== 2'b00) begin failures++; $display("FAIL reset_rc got=%b exp=00", rounding_mode); end
        checks++; if (precision_mode !== 2'b11) begin failures++; $display("FAIL reset_pc got=%b exp=11", precision_mode); end
        checks++; if (exc_mask !== 6'h3F) begin failures++; $display("FAIL reset_mask got=%h exp=3F", exc_mask); end
        checks++; if ({stk_empty, stk_full, stk_err, int_req} !== 4'b1000) begin
            failures++; $display("FAIL reset_status got=%b exp=1000", {stk_empty, stk_full, stk_err, int_req}); end
    endtask

    task automatic test_save_override();
        apply_reset();
        cw_push = 1; cw_we = 1; cw_in = 16'h0F7F;
        tick();
        idle();
        checks++; if (cw_out !== 16'h0F7F || rounding_mode !== 2'b11) begin
            failures++; $display("FAIL save_override got=%h/%b exp=0F7F/11", cw_out, rounding_mode); end
        checks++; if (stk_empty !== 1'b0) begin failures++; $display("FAIL save_nonempty got=%b exp=0", stk_empty); end
        cw_pop = 1;
        tick();
        idle();
        checks++; if (cw_out !== 16'h037F || stk_empty !== 1'b1) begin
            failures++; $display("FAIL restore got=%h empty=%b exp=037F empty=1", cw_out, stk_empty); end
    endtask

    task automatic test_stack_depth();
        logic [15:0] vals [5];
        int          err_cnt;
        apply_reset();
        vals = '{16'h0111, 16'h0222, 16'h0333, 16'h0444, 16'h0555};
        err_cnt = 0;
        for (int i = 0; i < 5; i++) begin
            cw_push = 1; cw_we = 1; cw_in = vals[i];
            tick();
            idle();
            if (stk_err) err_cnt++;
            if (i == 3) begin
                checks++; if (stk_full !== 1'b1) begin failures++; $display("FAIL full_after4 got=%b exp=1", stk_full); end
            end
        end
        checks++; if (err_cnt != 1 || cw_out !== 16'h0555) begin
            failures++; $display("FAIL overflow errs=%0d cw=%h exp errs=1 cw=0555", err_cnt, cw_out); end
        for (int i = 0; i < 4; i++) begin
            logic [15:0] exp_cw;
            exp_cw = (i == 3) ? CWR : vals[2 - i];
            cw_pop = 1;
            tick();
            idle();
            checks++; if (cw_out !== exp_cw || stk_err !== 1'b0) begin
                failures++; $display("FAIL pop%0d got=%h err=%b exp=%h err=0", i, cw_out, stk_err, exp_cw); end
        end
        cw_pop = 1; cw_we = 1; cw_in = 16'h0ABC;
        tick();
        idle();
        checks++; if (stk_err !== 1'b1 || cw_out !== CWR || stk_empty !== 1'b1) begin
            failures++; $display("FAIL underflow err=%b cw=%h exp err=1 cw=037F", stk_err, cw_out); end
        tick();
        checks++; if (stk_err !== 1'b0) begin failures++; $display("FAIL err_pulse got=%b exp=0", stk_err); end
    endtask

    task automatic test_exceptions();
        apply_reset();
        cw_we = 1; cw_in = 16'h0360;
        tick();
        idle();
        exc_valid = 1; exc_in = 6'h04;
        tick();
        idle();
        checks++; if (exc_flags !== 6'h04 || es !== 1'b1) begin
            failures++; $display("FAIL ze_flag got=%h es=%b exp=04 es=1", exc_flags, es); end
        checks++; if (int_req !== 1'b0) begin failures++; $display("FAIL int_lag got=%b exp=0", int_req); end
        tick();
        checks++; if (int_req !== 1'b1) begin failures++; $display("FAIL int_rise got=%b exp=1", int_req); end
        fclex = 1;
        tick();
        idle();
        checks++; if (exc_flags !== 6'h00 || es !== 1'b0) begin
            failures++; $display("FAIL fclex got=%h es=%b exp=00 es=0", exc_flags, es); end
        tick();
        checks++; if (int_req !== 1'b0) begin failures++; $display("FAIL int_fall got=%b exp=0", int_req); end
    endtask

    task automatic test_fclex_collision();
        apply_reset();
        cw_we = 1; cw_in = 16'h0360;
        exc_valid = 1; exc_in = 6'h05;
        tick();
        idle();
        fclex = 1; exc_valid = 1; exc_in = 6'h20;
        tick();
        idle();
        checks++; if (exc_flags !== 6'h20 || es !== 1'b0) begin
            failures++; $display("FAIL clex_collide got=%h es=%b exp=20 es=0", exc_flags, es); end
        exc_valid = 1; exc_in = 6'h04;
        tick();
        idle();
        tick();
        checks++; if (int_req !== 1'b1) begin failures++; $display("FAIL int_pre_iem got=%b exp=1", int_req); end
        cw_we = 1; cw_in = 16'h03E0;
        tick();
        idle();
        tick();
        checks++; if (int_req !== 1'b0 || es !== 1'b1) begin
            failures++; $display("FAIL iem_mask int=%b es=%b exp int=0 es=1", int_req, es); end
    endtask

    task automatic test_finit_async_reset();
        apply_reset();
        for (int i = 0; i < 2; i++) begin
            cw_push = 1; cw_we = 1; cw_in = 16'h0C00 + 16'(i);
            tick();
        end
        idle();
        exc_valid = 1; exc_in = 6'h3F;
        tick();
        idle();
        finit = 1; cw_we = 1; cw_push = 1; cw_in = 16'h0F00;
        tick();
        idle();
        checks++; if (cw_out !== CWR || exc_flags !== 6'h00 || stk_empty !== 1'b1 || stk_err !== 1'b0) begin
            failures++; $display("FAIL finit cw=%h fl=%h empty=%b err=%b exp 037F/00/1/0",
                                 cw_out, exc_flags, stk_empty, stk_err); end
        cw_we = 1; cw_in = 16'h0ABC; exc_valid = 1; exc_in = 6'h3F;
        tick();
        idle();
        cw_push = 1; cw_pop = 1;
        #2 reset = 1;
        #1;
        checks++; if (cw_out !== CWR || exc_flags !== 6'h00 || stk_empty !== 1'b1 || stk_full !== 1'b0
                      || stk_err !== 1'b0 || int_req !== 1'b0) begin
            failures++; $display("FAIL async_reset cw=%h fl=%h empty=%b err=%b int=%b",
                                 cw_out, exc_flags, stk_empty, stk_err, int_req); end
        idle();
        model_reset();
        @(posedge clk);
        #1;
        reset = 0;
    endtask

    task automatic test_random();
        apply_reset();
        for (int n = 0; n < 400; n++) begin
            cw_in     = 16'($urandom);
            cw_we     = ($urandom_range(0, 2) == 0);
            cw_push   = ($urandom_range(0, 3) == 0);
            cw_pop    = ($urandom_range(0, 3) == 0);
            finit     = ($urandom_range(0, 31) == 0);
            fclex     = ($urandom_range(0, 7) == 0);
            exc_valid = ($urandom_range(0, 1) == 0);
            exc_in    = 6'($urandom);
            tick();
            checks++; if (cw_out !== m_cw) begin failures++; $display("FAIL rnd_cw n=%0d got=%h exp=%h", n, cw_out, m_cw); end
            checks++; if (exc_flags !== m_flags) begin failures++; $display("FAIL rnd_flags n=%0d got=%h exp=%h", n, exc_flags, m_flags); end
            checks++; if (es !== m_es()) begin failures++; $display("FAIL rnd_es n=%0d got=%b exp=%b", n, es, m_es()); end
            checks++; if (int_req !== m_int) begin failures++; $display("FAIL rnd_int n=%0d got=%b exp=%b", n, int_req, m_int); end
            checks++; if (stk_err !== m_err) begin failures++; $display("FAIL rnd_err n=%0d got=%b exp=%b", n, stk_err, m_err); end
            checks++; if (stk_empty !== (m_stk.size() == 0) || stk_full !== (m_stk.size() == DEPTH)) begin
                failures++; $display("FAIL rnd_occ n=%0d empty=%b full=%b exp size=%0d", n, stk_empty, stk_full, m_stk.size()); end
            checks++; if ({rounding_mode, precision_mode, iem} !== {m_cw[11:8], m_cw[7]}) begin
                failures++; $display("FAIL rnd_fields n=%0d got=%b exp=%b", n, {rounding_mode, precision_mode, iem}, {m_cw[11:8], m_cw[7]}); end
        end
        idle();
    endtask

    initial begin
        reset = 1;
        idle();
        model_reset();
        #1;
        test_reset();
        test_save_override();
        test_stack_depth();
        test_exceptions();
        test_fclex_collision();
        test_finit_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
